// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: frame receiver, E0/F0 prefix decoder, 512-entry key bitmap
// and a show-ahead key-event FIFO for the game movement logic.
module ps2_key_tracker #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [8:0] key_query,
    output logic       key_down,
    output logic [9:0] key_count,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic       overflow,
    input  logic       clear_overflow,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EW = 11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } dec_state_e;

    // Pin synchronisers; a falling edge is seen between the two oldest clock samples
    logic [SYNC_STAGES-1:0] sclk_q, sdat_q;
    logic                   fall_c, din_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_q <= '0;
            sdat_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], ps2_clk};
            sdat_q <= {sdat_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign fall_c = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES-2];
    assign din_c  = sdat_q[SYNC_STAGES-1];

    // Frame receiver
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        byte_valid_d = 1'b0;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;
        if (fall_c) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd0) begin
                if (!din_c) bit_cnt_d = 4'd1;
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {din_c, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                par_d     = din_c;
                bit_cnt_d = 4'd10;
            end else begin
                bit_cnt_d = 4'd0;
                if (~^{shift_q, par_q}) perr_d = 1'b1;
                else if (!din_c)        ferr_d = 1'b1;
                else                    byte_valid_d = 1'b1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_d     = '0;
                bit_cnt_d = 4'd0;
                ferr_d    = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

    // Prefix decoder; shift_q still holds the received byte while byte_valid_q is high
    dec_state_e state_q, state_d;
    logic       ev_q, ev_d;
    logic [7:0] ev_code_q, ev_code_d;
    logic       ev_ext_q, ev_ext_d;
    logic       ev_brk_q, ev_brk_d;

    always_comb begin
        state_d   = state_q;
        ev_d      = 1'b0;
        ev_code_d = shift_q;
        ev_ext_d  = (state_q == S_E0) || (state_q == S_E0F0);
        ev_brk_d  = (state_q == S_F0) || (state_q == S_E0F0);
        if (perr_q || ferr_q) begin
            state_d = S_IDLE;
        end else if (byte_valid_q) begin
            case (shift_q)
                8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_d = S_IDLE;
                8'hE0: begin
                    if (state_q == S_IDLE) state_d = S_E0;
                end
                8'hF0: begin
                    if (state_q == S_IDLE)    state_d = S_F0;
                    else if (state_q == S_E0) state_d = S_E0F0;
                end
                default: begin
                    ev_d    = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            ev_q      <= 1'b0;
            ev_code_q <= '0;
            ev_ext_q  <= 1'b0;
            ev_brk_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ev_q      <= ev_d;
            ev_code_q <= ev_code_d;
            ev_ext_q  <= ev_ext_d;
            ev_brk_q  <= ev_brk_d;
        end
    end

    // Event commit into the key bitmap
    logic [511:0] bitmap_q, bitmap_d;
    logic [9:0]   count_q, count_d;
    logic [8:0]   idx_c;
    logic         cur_c, rep_c;
    logic         key_down_q;

    assign idx_c = {ev_ext_q, ev_code_q};
    assign cur_c = bitmap_q[idx_c];
    assign rep_c = ~ev_brk_q & cur_c;

    always_comb begin
        bitmap_d = bitmap_q;
        count_d  = count_q;
        if (ev_q) begin
            if (!ev_brk_q && !cur_c) begin
                bitmap_d[idx_c] = 1'b1;
                count_d         = count_q + 10'd1;
            end else if (ev_brk_q && cur_c) begin
                bitmap_d[idx_c] = 1'b0;
                count_d         = count_q - 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bitmap_q   <= '0;
            count_q    <= '0;
            key_down_q <= 1'b0;
        end else begin
            bitmap_q   <= bitmap_d;
            count_q    <= count_d;
            key_down_q <= bitmap_q[key_query];
        end
    end

    assign key_down  = key_down_q;
    assign key_count = count_q;

    // Show-ahead event FIFO; a push into a full FIFO only succeeds alongside a pop
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, fill_c;
    logic          empty_c, full_c, pop_c, push_c, drop_c;
    logic          ovf_q, ovf_d;

    assign fill_c  = wr_ptr_q - rd_ptr_q;
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (fill_c == PW'(FIFO_DEPTH));
    assign pop_c   = ~empty_c & evt_ready;
    assign push_c  = ev_q & (~full_c | pop_c);
    assign drop_c  = ev_q & full_c & ~pop_c;
    assign ovf_d   = drop_c | (ovf_q & ~clear_overflow);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {ev_code_q, ev_ext_q, ev_brk_q, rep_c};
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
            ovf_q <= ovf_d;
        end
    end

    assign evt_valid = ~empty_c;
    assign {evt_code, evt_ext, evt_break, evt_repeat} = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised and directed bench for ps2_key_tracker against a behavioural keyboard model.
module tb_ps2_key_tracker;

    localparam int DEPTH = 8;
    localparam int TMO   = 600;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] key_query = '0;
    logic       evt_ready = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       key_down, evt_valid, evt_ext, evt_break, evt_repeat;
    logic       overflow, parity_err, frame_err;
    logic [9:0] key_count;
    logic [7:0] evt_code;

    ps2_key_tracker #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (3)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .key_query     (key_query),
        .key_down      (key_down),
        .key_count     (key_count),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_ext       (evt_ext),
        .evt_break     (evt_break),
        .evt_repeat    (evt_repeat),
        .overflow      (overflow),
        .clear_overflow(clear_overflow),
        .parity_err    (parity_err),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: held keys as a flat array, pending prefixes as two flags
    typedef struct {
        logic [7:0] code;
        bit         ext;
        bit         brk;
        bit         rep;
    } ev_t;

    bit  bm [512];
    int  m_count;
    bit  m_ovf;
    bit  ext_p, brk_p;
    ev_t q[$];
    int  perr_seen = 0, ferr_seen = 0, perr_exp = 0, ferr_exp = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (parity_err) perr_seen++;
            if (frame_err)  ferr_seen++;
        end
    end

    function automatic bit is_special(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

    task automatic model_reset();
        foreach (bm[i]) bm[i] = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        ext_p   = 1'b0;
        brk_p   = 1'b0;
        q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ev_t e;
        int  idx;
        if (bad_par || bad_stop) begin
            if (bad_par) perr_exp++;
            else         ferr_exp++;
            ext_p = 1'b0;
            brk_p = 1'b0;
        end else if (is_special(b)) begin
            ext_p = 1'b0;
            brk_p = 1'b0;
        end else if (b == 8'hE0) begin
            if (!ext_p && !brk_p) ext_p = 1'b1;
        end else if (b == 8'hF0) begin
            brk_p = 1'b1;
        end else begin
            idx    = (ext_p ? 256 : 0) + int'(b);
            e.code = b;
            e.ext  = ext_p;
            e.brk  = brk_p;
            e.rep  = !brk_p && bm[idx];
            if (!brk_p && !bm[idx]) begin
                bm[idx] = 1'b1;
                m_count++;
            end else if (brk_p && bm[idx]) begin
                bm[idx] = 1'b0;
                m_count--;
            end
            if (q.size() < DEPTH) q.push_back(e);
            else                  m_ovf = 1'b1;
            ext_p = 1'b0;
            brk_p = 1'b0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        cyc(4);
        ps2_clk = 1'b0;
        cyc(8);
        ps2_clk = 1'b1;
        cyc(4);
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        cyc(6);
        model_byte(b, bad_par, bad_stop);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, 1'b0, 1'b0);
    endtask

    task automatic query(input logic [8:0] idx);
        key_query = idx;
        cyc(2);
        chk($sformatf("key_down[%03h]", idx), 32'(key_down), 32'(bm[idx]));
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".key_count"}, 32'(key_count), 32'(m_count));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(q.size() != 0));
    endtask

    task automatic pop_one();
        chk("pop.valid", 32'(evt_valid), 32'd1);
        chk("pop.code", 32'(evt_code), 32'(q[0].code));
        chk("pop.ext", 32'(evt_ext), 32'(q[0].ext));
        chk("pop.break", 32'(evt_break), 32'(q[0].brk));
        chk("pop.repeat", 32'(evt_repeat), 32'(q[0].rep));
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        void'(q.pop_front());
        cyc(1);
    endtask

    task automatic drain();
        while (q.size() > 0) pop_one();
        chk("drain.evt_valid", 32'(evt_valid), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] ovf_codes [9];
        logic [7:0] b;
        int         r;

        ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        model_reset();
        cyc(3);
        chk("rst.evt_valid", 32'(evt_valid), 32'd0);
        chk("rst.key_count", 32'(key_count), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        chk("rst.key_down", 32'(key_down), 32'd0);
        chk("rst.evt_code", 32'(evt_code), 32'd0);
        chk("rst.errs", 32'({parity_err, frame_err}), 32'd0);
        rstn = 1'b1;
        cyc(5);

        // Single make
        send_ok(8'h1C);
        chk("t1.code", 32'(evt_code), 32'h1C);
        check_state("t1");
        query(9'h01C);
        drain();

        // Extended make and break
        send_ok(8'hE0); send_ok(8'h75);
        query(9'h175);
        check_state("t2a");
        send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
        query(9'h175);
        query(9'h075);
        check_state("t2b");
        drain();

        // Typematic repeat
        send_ok(8'h1C);
        check_state("t3a");
        send_ok(8'h1C);
        check_state("t3b");
        send_ok(8'hF0); send_ok(8'h1C);
        check_state("t3c");
        drain();

        // Corrupted break prefix
        send(8'hF0, 1'b1, 1'b0);
        chk("t4.parity_err", 32'(perr_seen), 32'(perr_exp));
        send_ok(8'h1C);
        query(9'h01C);
        check_state("t4");
        drain();
        send_ok(8'hF0); send_ok(8'h1C);
        drain();

        // Partial frame times out
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_data = 1'b1;
        cyc(TMO + 10);
        ferr_exp++;
        ext_p = 1'b0;
        brk_p = 1'b0;
        chk("t5.frame_err", 32'(ferr_seen), 32'(ferr_exp));
        send_ok(8'h23);
        check_state("t5");
        drain();
        send_ok(8'hF0); send_ok(8'h23);
        drain();

        // FIFO overflow
        foreach (ovf_codes[i]) send_ok(ovf_codes[i]);
        check_state("t6");
        chk("t6.key_count9", 32'(key_count), 32'd9);
        foreach (ovf_codes[i]) query({1'b0, ovf_codes[i]});
        clear_overflow = 1'b1;
        cyc(1);
        clear_overflow = 1'b0;
        m_ovf = 1'b0;
        cyc(1);
        chk("t6.ovf_cleared", 32'(overflow), 32'd0);
        drain();

        // Reset in the middle of a frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        rstn = 1'b0;
        model_reset();
        cyc(2);
        check_state("t7");
        rstn = 1'b1;
        cyc(4);
        query(9'h015);
        send_ok(8'h1C);
        check_state("t7b");
        drain();

        // Random byte stream
        for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12)      send_ok(8'hE0);
            else if (r < 24) send_ok(8'hF0);
            else if (r < 30) begin
                case ($urandom_range(0, 6))
                    0: b = 8'h00; 1: b = 8'hAA; 2: b = 8'hE1; 3: b = 8'hEE;
                    4: b = 8'hFA; 5: b = 8'hFE; default: b = 8'hFF;
                endcase
                send_ok(b);
            end
            else if (r < 34) send(8'(16 + $urandom_range(0, 15)), 1'b1, 1'b0);
            else if (r < 37) send(8'(16 + $urandom_range(0, 15)), 1'b0, 1'b1);
            else             send_ok(8'(16 + $urandom_range(0, 15)));
            check_state("rnd");
            query(9'({$urandom_range(0, 1), 4'h1, 4'($urandom_range(0, 15))}));
            if ($urandom_range(0, 9) < 4) drain();
            if (m_ovf && $urandom_range(0, 3) == 0) begin
                clear_overflow = 1'b1;
                cyc(1);
                clear_overflow = 1'b0;
                m_ovf = 1'b0;
                cyc(1);
            end
        end
        drain();
        check_state("end");
        chk("end.parity_errs", 32'(perr_seen), 32'(perr_exp));
        chk("end.frame_errs", 32'(ferr_seen), 32'(ferr_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
